// File: rtl/tc_pkg.sv
// Shared types and defaults for the tensor-core partial-sum buffer.
package tc_pkg;

    localparam int unsigned DW_IN_DEF  = 8;
    localparam int unsigned DW_ACC_DEF = 16;

    // Buffer operating mode: accumulate incoming beats or drain rows out.
    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Saturation bounds for the default accumulator width.
    localparam logic [DW_ACC_DEF-1:0] ACC_MAX_DEF = {1'b0, {(DW_ACC_DEF-1){1'b1}}};
    localparam logic [DW_ACC_DEF-1:0] ACC_MIN_DEF = {1'b1, {(DW_ACC_DEF-1){1'b0}}};

endpackage

// File: rtl/tc_sat_add.sv
// One lane of the accumulate path: sign-extend the lane, add to the
// accumulator (or to zero on clear), and optionally clamp on overflow.
module tc_sat_add
    import tc_pkg::*;
#(
    parameter int unsigned DW_IN  = DW_IN_DEF,
    parameter int unsigned DW_ACC = DW_ACC_DEF,
    parameter int unsigned SAT    = 1
) (
    input  logic [DW_IN-1:0]  lane_i,
    input  logic [DW_ACC-1:0] acc_i,
    input  logic              clear_i,
    output logic [DW_ACC-1:0] sum_c_o
);

    localparam logic [DW_ACC-1:0] MAX_V = {1'b0, {(DW_ACC-1){1'b1}}};
    localparam logic [DW_ACC-1:0] MIN_V = {1'b1, {(DW_ACC-1){1'b0}}};

    logic [DW_ACC-1:0] ext;
    logic [DW_ACC-1:0] base;
    logic [DW_ACC:0]   wide;
    logic              ovf;

    // One extra bit of headroom; overflow when the top two bits disagree.
    always_comb begin
        ext     = DW_ACC'($signed(lane_i));
        base    = clear_i ? '0 : acc_i;
        wide    = {base[DW_ACC-1], base} + {ext[DW_ACC-1], ext};
        ovf     = wide[DW_ACC] ^ wide[DW_ACC-1];
        sum_c_o = wide[DW_ACC-1:0];
        if ((SAT != 0) && ovf) begin
            sum_c_o = wide[DW_ACC] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/tc_psum_buf.sv
// Partial-sum buffer: accumulates TILE_M-lane column segments into an
// M x N signed array, then drains it row by row and clears itself.
module tc_psum_buf
    import tc_pkg::*;
#(
    parameter int unsigned M      = 16,
    parameter int unsigned N      = 16,
    parameter int unsigned TILE_M = 4,
    parameter int unsigned DW_IN  = DW_IN_DEF,
    parameter int unsigned DW_ACC = DW_ACC_DEF,
    parameter int unsigned DW_POS = 4,
    parameter int unsigned SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW_POS-1:0]        in_row,
    input  logic [DW_POS-1:0]        in_col,
    input  logic                     in_clear,
    input  logic [TILE_M*DW_IN-1:0]  in_data,
    input  logic                     drain_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW_POS-1:0]        out_row,
    output logic [N*DW_ACC-1:0]      out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err
);

    localparam logic [DW_POS-1:0] LAST_ROW = DW_POS'(M-1);

    state_e            state_q, state_d;
    logic [DW_POS-1:0] out_row_q, out_row_d;
    logic              err_q, err_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              busy_q;
    logic              clear_all;

    logic [DW_ACC-1:0] acc_q [M][N];

    logic              accept;
    logic              col_ok;
    logic              wr_en;
    logic [DW_POS-1:0] wr_col;
    logic [TILE_M-1:0] lane_ok;
    logic [DW_POS-1:0] lane_row [TILE_M];
    logic [DW_ACC-1:0] lane_sum [TILE_M];

    // Beat acceptance and column range check; out-of-range columns drop the beat.
    assign accept = in_valid && in_ready_q;
    assign col_ok = (32'(in_col) < N);
    assign wr_en  = accept && col_ok;
    assign wr_col = col_ok ? in_col : '0;

    // Per-lane row range check and adder; dropped lanes read a safe index.
    for (genvar i = 0; i < int'(TILE_M); i++) begin : g_lane
        logic [31:0] row_full;
        assign row_full    = 32'(in_row) + 32'(i);
        assign lane_ok[i]  = (row_full < M);
        assign lane_row[i] = lane_ok[i] ? DW_POS'(row_full) : '0;

        tc_sat_add #(
            .DW_IN  (DW_IN),
            .DW_ACC (DW_ACC),
            .SAT    (SAT)
        ) u_add (
            .lane_i  (in_data[i*DW_IN +: DW_IN]),
            .acc_i   (acc_q[lane_row[i]][wr_col]),
            .clear_i (in_clear),
            .sum_c_o (lane_sum[i])
        );
    end

    // Next-state: drain on request, advance rows on handshake, clear after last row.
    always_comb begin
        state_d   = state_q;
        out_row_d = out_row_q;
        err_d     = err_q;
        clear_all = 1'b0;

        if (accept && (!col_ok || !(&lane_ok))) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_ACC: begin
                if (drain_start) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (out_row_q == LAST_ROW) begin
                        state_d   = ST_ACC;
                        out_row_d = '0;
                        clear_all = 1'b1;
                    end else begin
                        out_row_d = out_row_q + DW_POS'(1);
                    end
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            out_row_q   <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_row_q   <= out_row_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == ST_ACC);
            out_valid_q <= (state_d == ST_DRAIN);
            out_last_q  <= (state_d == ST_DRAIN) && (out_row_d == LAST_ROW);
            busy_q      <= (state_d == ST_DRAIN);
        end
    end

    // Accumulator array: cleared on reset or drain completion, else lane writes.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            for (int r = 0; r < int'(M); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    acc_q[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(TILE_M); i++) begin
                if (lane_ok[i]) begin
                    acc_q[lane_row[i]][wr_col] <= lane_sum[i];
                end
            end
        end
    end

    // Row mux onto the output bus; the array is frozen while draining.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < int'(N); j++) begin
            out_data[j*DW_ACC +: DW_ACC] = acc_q[out_row_q][j];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
